// File: rtl/multi_cycle_cu_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcode/func
// fields, PC-select and ALU operation codes, and the decoded-instruction record.
package multi_cycle_cu_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5,
        S_ERR  = 3'd6
    } state_e;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_HALT   = 6'b111111;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] PCSEL_PC4 = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_JMP = 2'b10;
    localparam logic [1:0] PCSEL_RSV = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;

    typedef struct packed {
        logic       legal;
        logic       is_j;
        logic       is_halt;
        logic       is_branch;
        logic       is_lw;
        logic       is_sw;
        logic       reg_dst;
        logic       db;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       ext_sel;
        logic [2:0] alu_op;
    } dec_t;

    // bltz shares the REGIMM opcode; rt is not visible here, so REGIMM means bltz.
    function automatic logic branch_taken(input logic [5:0] op, input logic zero,
                                          input logic sign);
        logic taken;
        case (op)
            OP_BEQ:    taken = zero;
            OP_BNE:    taken = ~zero;
            OP_REGIMM: taken = sign;
            default:   taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/multi_cycle_cu_decode.sv
// Combinational Op/Func decode: legality, instruction class and datapath selects.
module cu_decode
    import multi_cycle_cu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output dec_t       dec
);

    // Instruction class and select decode
    always_comb begin
        dec         = '0;
        dec.alu_op  = ALU_ADD;
        dec.ext_sel = 1'b1;
        case (op)
            OP_RTYPE: begin
                dec.reg_dst = 1'b1;
                dec.legal   = 1'b1;
                case (func)
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    FN_SLL: begin
                        dec.alu_op    = ALU_SLL;
                        dec.alu_src_a = 1'b1;
                    end
                    default: dec.legal = 1'b0;
                endcase
            end
            OP_ADDIU: begin
                dec.legal     = 1'b1;
                dec.alu_src_b = 1'b1;
            end
            OP_SLTI: begin
                dec.legal     = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.alu_op    = ALU_SLT;
            end
            // Logical immediates are zero-extended
            OP_ANDI: begin
                dec.legal     = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.ext_sel   = 1'b0;
                dec.alu_op    = ALU_AND;
            end
            OP_ORI: begin
                dec.legal     = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.ext_sel   = 1'b0;
                dec.alu_op    = ALU_OR;
            end
            OP_LW: begin
                dec.legal     = 1'b1;
                dec.is_lw     = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.db        = 1'b1;
            end
            OP_SW: begin
                dec.legal     = 1'b1;
                dec.is_sw     = 1'b1;
                dec.alu_src_b = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_REGIMM: begin
                dec.legal     = 1'b1;
                dec.is_branch = 1'b1;
                dec.alu_op    = ALU_SUB;
            end
            OP_J: begin
                dec.legal = 1'b1;
                dec.is_j  = 1'b1;
            end
            OP_HALT: begin
                dec.legal   = 1'b1;
                dec.is_halt = 1'b1;
            end
            default: dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_cu.sv
// Multi-cycle MIPS control unit: IF/ID/EXE/MEM/WB sequencer with memory-wait
// timeout, terminal HALT/ERR states and a saturating retired-instruction counter.
module multi_cycle_cu
    import multi_cycle_cu_pkg::*;
#(
    parameter int ALUOP_W  = 3,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               RST,
    input  logic [5:0]         Op,
    input  logic [5:0]         Func,
    input  logic               ZERO,
    input  logic               SIGN,
    input  logic               imem_ack,
    input  logic               dmem_ack,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic               IRWr,
    output logic               PCWr,
    output logic [1:0]         PCSel,
    output logic               RegWr,
    output logic               RegDst,
    output logic               DB,
    output logic               ALUScrA,
    output logic               ALUScrB,
    output logic               ExtSel,
    output logic [ALUOP_W-1:0] ALUop,
    output logic [2:0]         state,
    output logic               halted,
    output logic               error,
    output logic [CNT_W-1:0]   retired
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    dec_t               dec_s;

    cu_decode u_decode (
        .op   (Op),
        .func (Func),
        .dec  (dec_s)
    );

    // Next state, wait counting and strobes; strobes are held low while RST is asserted
    always_comb begin
        state_d  = state_q;
        wait_d   = '0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        IRWr     = 1'b0;
        PCWr     = 1'b0;
        PCSel    = PCSEL_PC4;
        RegWr    = 1'b0;
        if (RST) begin
            case (state_q)
                S_IF: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        IRWr    = 1'b1;
                        state_d = S_ID;
                    end else if (wait_q == WAIT_LAST) begin
                        state_d = S_ERR;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                S_ID: begin
                    if (dec_s.is_halt) begin
                        state_d = S_HALT;
                    end else if (dec_s.is_j) begin
                        PCWr    = 1'b1;
                        PCSel   = PCSEL_JMP;
                        state_d = S_IF;
                    end else if (!dec_s.legal) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_EXE;
                    end
                end
                S_EXE: begin
                    if (dec_s.is_branch) begin
                        PCWr    = 1'b1;
                        PCSel   = branch_taken(Op, ZERO, SIGN) ? PCSEL_BR : PCSEL_PC4;
                        state_d = S_IF;
                    end else if (dec_s.is_lw || dec_s.is_sw) begin
                        state_d = S_MEM;
                    end else begin
                        state_d = S_WB;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = dec_s.is_sw;
                    if (dmem_ack) begin
                        PCWr    = dec_s.is_sw;
                        state_d = dec_s.is_sw ? S_IF : S_WB;
                    end else if (wait_q == WAIT_LAST) begin
                        state_d = S_ERR;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    RegWr   = 1'b1;
                    PCWr    = 1'b1;
                    state_d = S_IF;
                end
                S_HALT:  state_d = S_HALT;
                S_ERR:   state_d = S_ERR;
                default: state_d = S_ERR;
            endcase
        end else begin
            state_d = S_IF;
        end
    end

    // Saturating count of PC updates
    always_comb begin
        if (PCWr && (retired_q != {CNT_W{1'b1}})) begin
            retired_d = retired_q + CNT_W'(1);
        end else begin
            retired_d = retired_q;
        end
    end

    // State, wait and retired registers
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IF;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    assign RegDst  = dec_s.reg_dst;
    assign DB      = dec_s.db;
    assign ALUScrA = dec_s.alu_src_a;
    assign ALUScrB = dec_s.alu_src_b;
    assign ExtSel  = dec_s.ext_sel;
    assign ALUop   = ALUOP_W'(dec_s.alu_op);
    assign state   = state_q;
    assign halted  = (state_q == S_HALT);
    assign error   = (state_q == S_ERR);
    assign retired = retired_q;

endmodule

// File: tb/tb_multi_cycle_cu.sv
// Scoreboard bench for multi_cycle_cu: per-cycle expected outputs are queued with
// the stimulus that produces them and compared cycle by cycle against the DUT.
module tb_multi_cycle_cu;
    import multi_cycle_cu_pkg::*;

    localparam int CNT_W    = 4;
    localparam int WAIT_MAX = 15;
    localparam int TERM_CYC = 20;

    logic             clk = 1'b0;
    logic             RST = 1'b0;
    logic [5:0]       Op = 6'd0;
    logic [5:0]       Func = 6'd0;
    logic             ZERO = 1'b0;
    logic             SIGN = 1'b0;
    logic             imem_ack = 1'b0;
    logic             dmem_ack = 1'b0;
    logic             imem_req, dmem_req, dmem_we, IRWr, PCWr, RegWr;
    logic             RegDst, DB, ALUScrA, ALUScrB, ExtSel, halted, error;
    logic [1:0]       PCSel;
    logic [2:0]       ALUop;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    multi_cycle_cu #(.ALUOP_W(3), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .RST(RST), .Op(Op), .Func(Func), .ZERO(ZERO), .SIGN(SIGN),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .IRWr(IRWr), .PCWr(PCWr),
        .PCSel(PCSel), .RegWr(RegWr), .RegDst(RegDst), .DB(DB), .ALUScrA(ALUScrA),
        .ALUScrB(ALUScrB), .ExtSel(ExtSel), .ALUop(ALUop), .state(state),
        .halted(halted), .error(error), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       st;
        logic             ireq, irwr, dreq, dwe, pcwr;
        logic [1:0]       pcsel;
        logic             regwr, db, regdst, srcb;
        logic [2:0]       aluop;
        logic [CNT_W-1:0] ret;
        logic             halted, error;
    } obs_t;

    obs_t       exp_q[$];
    logic [1:0] stim_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    logic [CNT_W-1:0] m_ret = '0;
    logic       m_regdst, m_srcb, m_db;
    logic [2:0] m_alu;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.st = state; o.ireq = imem_req; o.irwr = IRWr; o.dreq = dmem_req;
        o.dwe = dmem_we; o.pcwr = PCWr; o.pcsel = PCSel; o.regwr = RegWr;
        o.db = DB; o.regdst = RegDst; o.srcb = ALUScrB; o.aluop = ALUop;
        o.ret = retired; o.halted = halted; o.error = error;
        return o;
    endfunction

    function automatic logic m_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd0) return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        else return op inside {6'b001001, 6'b001100, 6'b001101, 6'b001010, 6'b100011,
                               6'b101011, 6'b000100, 6'b000101, 6'b000001, 6'b000010, 6'b111111};
    endfunction

    task automatic set_model(input logic [5:0] op, input logic [5:0] fn);
        m_regdst = (op == 6'd0);
        m_srcb   = op inside {6'b001001, 6'b001010, 6'b001100, 6'b001101, 6'b100011, 6'b101011};
        m_db     = (op == 6'b100011);
        case (op)
            6'b000000: case (fn)
                6'b100010: m_alu = ALU_SUB;
                6'b100100: m_alu = ALU_AND;
                6'b100101: m_alu = ALU_OR;
                6'b101010: m_alu = ALU_SLT;
                6'b000000: m_alu = ALU_SLL;
                default:   m_alu = ALU_ADD;
            endcase
            6'b001010: m_alu = ALU_SLT;
            6'b001100: m_alu = ALU_AND;
            6'b001101: m_alu = ALU_OR;
            6'b000100, 6'b000101, 6'b000001: m_alu = ALU_SUB;
            default:   m_alu = ALU_ADD;
        endcase
    endtask

    task automatic push(input logic [2:0] st, input logic ireq, input logic irwr,
                        input logic dreq, input logic dwe, input logic pcwr,
                        input logic [1:0] pcsel, input logic regwr,
                        input logic iack, input logic dack);
        obs_t e;
        e.st = st; e.ireq = ireq; e.irwr = irwr; e.dreq = dreq; e.dwe = dwe;
        e.pcwr = pcwr; e.pcsel = pcsel; e.regwr = regwr; e.db = m_db;
        e.regdst = m_regdst; e.srcb = m_srcb; e.aluop = m_alu; e.ret = m_ret;
        e.halted = (st == 3'd5); e.error = (st == 3'd6);
        exp_q.push_back(e);
        stim_q.push_back({iack, dack});
        if (pcwr && (m_ret != {CNT_W{1'b1}})) m_ret = m_ret + CNT_W'(1);
    endtask

    // Acks default high outside the request being stalled, so stray acks are exercised
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                         input logic sign, input int iwait, input int dwait);
        logic taken;
        logic is_sw;
        Op = op; Func = fn; ZERO = zero; SIGN = sign;
        set_model(op, fn);
        is_sw = (op == 6'b101011);
        for (int i = 0; i < iwait; i++) push(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        push(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        if (op == 6'b000010) begin
            push(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1);
            return;
        end
        push(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        if (op == 6'b111111 || !m_legal(op, fn)) begin
            for (int i = 0; i < TERM_CYC; i++)
                push((op == 6'b111111) ? 3'd5 : 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
            return;
        end
        if (op inside {6'b000100, 6'b000101, 6'b000001}) begin
            taken = (op == 6'b000100) ? zero : (op == 6'b000101) ? !zero : sign;
            push(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, taken ? 2'b01 : 2'b00, 1'b0, 1'b1, 1'b1);
            return;
        end
        push(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        if (op == 6'b100011 || is_sw) begin
            for (int i = 0; i < dwait; i++) push(3'd3, 1'b0, 1'b0, 1'b1, is_sw, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
            push(3'd3, 1'b0, 1'b0, 1'b1, is_sw, is_sw, 2'b00, 1'b0, 1'b1, 1'b1);
            if (is_sw) return;
        end
        push(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic drain(input string name);
        int         cyc;
        logic [1:0] s;
        obs_t       e;
        cyc = 0;
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            imem_ack = s[1];
            dmem_ack = s[0];
            @(negedge clk);
            check_eq($sformatf("%s.c%0d", name, cyc), 32'(observe()), 32'(e));
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic do_reset(input string name);
        @(posedge clk);
        #1;
        RST = 1'b0;
        #1;
        check_eq({name, ".state"}, 32'(state), 32'd0);
        check_eq({name, ".retired"}, 32'(retired), 32'd0);
        check_eq({name, ".strobes"}, 32'({imem_req, dmem_req, IRWr, PCWr, RegWr}), 32'd0);
        check_eq({name, ".flags"}, 32'({halted, error}), 32'd0);
        @(posedge clk);
        #1;
        RST = 1'b1;
        m_ret = '0;
        #1;
        check_eq({name, ".first_ireq"}, 32'(imem_req), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset("rst0");
        build(OP_RTYPE, FN_ADD, 1'b0, 1'b0, 0, 0); drain("add");
        check_eq("add.retired", 32'(retired), 32'd1);
        build(OP_RTYPE, FN_SUB, 1'b0, 1'b0, 2, 0); drain("sub_iwait");
        build(OP_RTYPE, FN_AND, 1'b0, 1'b0, 0, 0); drain("and");
        build(OP_RTYPE, FN_OR,  1'b0, 1'b0, 0, 0); drain("or");
        build(OP_RTYPE, FN_SLT, 1'b0, 1'b0, 0, 0); drain("slt");
        build(OP_RTYPE, FN_SLL, 1'b0, 1'b0, 1, 0); drain("sll");
        build(OP_ADDIU, 6'd5, 1'b0, 1'b0, 0, 0); drain("addiu");
        build(OP_ANDI,  6'd5, 1'b0, 1'b0, 0, 0); drain("andi");
        build(OP_ORI,   6'd5, 1'b0, 1'b0, 0, 0); drain("ori");
        build(OP_SLTI,  6'd5, 1'b0, 1'b0, 0, 0); drain("slti");
        build(OP_SW,    6'd0, 1'b0, 1'b0, 0, 0); drain("sw");
        build(OP_LW,    6'd0, 1'b0, 1'b0, 0, 3); drain("lw_dwait3");
        build(OP_LW,    6'd0, 1'b0, 1'b0, 0, 0); drain("lw");
        build(OP_SW,    6'd0, 1'b0, 1'b0, 0, 2); drain("sw_dwait2");
        build(OP_BEQ,   6'd0, 1'b1, 1'b0, 0, 0); drain("beq_taken");
        build(OP_BEQ,   6'd0, 1'b0, 1'b0, 0, 0); drain("beq_not");
        build(OP_BNE,   6'd0, 1'b1, 1'b0, 0, 0); drain("bne_not");
        build(OP_BNE,   6'd0, 1'b0, 1'b0, 0, 0); drain("bne_taken");
        build(OP_REGIMM, 6'd0, 1'b0, 1'b1, 0, 0); drain("bltz_taken");
        build(OP_REGIMM, 6'd0, 1'b1, 1'b0, 0, 0); drain("bltz_not");
        build(OP_J,     6'd0, 1'b0, 1'b0, 0, 0); drain("j");
        check_eq("retired_sat", 32'(retired), 32'hF);
        build(OP_HALT,  6'd0, 1'b0, 1'b0, 0, 0); drain("halt");

        do_reset("rst1");
        build(OP_RTYPE, 6'b111111, 1'b0, 1'b0, 0, 0); drain("illegal_func");

        do_reset("rst2");
        build(6'b010000, 6'd0, 1'b0, 1'b0, 0, 0); drain("illegal_op");

        do_reset("rst3");
        Op = OP_RTYPE; Func = FN_ADD;
        set_model(OP_RTYPE, FN_ADD);
        for (int i = 0; i < WAIT_MAX; i++) push(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < TERM_CYC; i++) push(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        drain("imem_timeout");

        do_reset("rst4");
        build(OP_J, 6'd0, 1'b0, 1'b0, 0, 0); drain("j2");
        Op = OP_LW; Func = 6'd0;
        set_model(OP_LW, 6'd0);
        push(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        push(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        push(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        push(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        drain("lw_pre_rst");
        dmem_ack = 1'b0;
        check_eq("mid_mem.req_before", 32'({state, dmem_req}), 32'({3'd3, 1'b1}));
        RST = 1'b0;
        #1;
        check_eq("mid_mem.dreq", 32'(dmem_req), 32'd0);
        check_eq("mid_mem.state", 32'(state), 32'd0);
        check_eq("mid_mem.retired", 32'(retired), 32'd0);
        check_eq("mid_mem.pcwr_regwr", 32'({PCWr, RegWr}), 32'd0);
        @(posedge clk);
        #1;
        RST = 1'b1;
        m_ret = '0;
        #1;
        check_eq("after_rst.ireq", 32'(imem_req), 32'd1);
        build(OP_RTYPE, FN_ADD, 1'b0, 1'b0, 0, 0); drain("add_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
